// File: rtl/tx_byte_buffer_pkg.sv
// Shared definitions for the UART transmit byte buffer: byte width and
// sequencer state encoding.
package tx_byte_buffer_pkg;

  localparam int unsigned WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_byte_buffer_if.sv
// Bus between sys_control / UART TX side and tx_byte_buffer.
// The master drives pushes and the synchronized busy flag; the slave is the buffer.
interface tx_byte_buffer_if
  import tx_byte_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) ();

  logic                   wr_valid_in;
  logic [WIDTH-1:0]       wr_data_in;
  logic                   busy_in;
  logic                   tx_valid_out;
  logic [WIDTH-1:0]       tx_data_out;
  logic                   full_out;
  logic                   empty_out;
  logic [$clog2(DEPTH):0] count_out;
  logic                   overflow_out;
  logic                   timeout_out;

  modport master (
    output wr_valid_in, wr_data_in, busy_in,
    input  tx_valid_out, tx_data_out, full_out, empty_out, count_out,
           overflow_out, timeout_out
  );

  modport slave (
    input  wr_valid_in, wr_data_in, busy_in,
    output tx_valid_out, tx_data_out, full_out, empty_out, count_out,
           overflow_out, timeout_out
  );

endinterface

// File: rtl/tx_byte_buffer_sync_fifo.sv
// Single-clock circular byte FIFO with occupancy count and a registered
// overflow pulse for pushes rejected while full.
module sync_fifo
  import tx_byte_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign head_o     = mem_q[rd_ptr_q];

  // Full is judged on pre-edge occupancy, so a same-edge pop never frees room.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= push_i && full_o;
    end
  end

endmodule

// File: rtl/tx_byte_buffer.sv
// Byte FIFO plus transmit sequencer: issues one byte as a stretched valid,
// then paces the next byte on the synchronized UART TX busy handshake.
module tx_byte_buffer
  import tx_byte_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  tx_byte_buffer_if.slave  bus
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [15:0]   TMO_LOAD  = 16'(TIMEOUT - 1);

  tx_state_e        state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q;
  logic             tmo_pulse_q, tmo_pulse_d;
  logic             pop;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (bus.wr_valid_in),
    .push_data_i (bus.wr_data_in),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (bus.full_out),
    .empty_o     (fifo_empty),
    .count_o     (bus.count_out),
    .overflow_o  (bus.overflow_out)
  );

  assign bus.empty_out    = fifo_empty;
  assign bus.tx_valid_out = valid_q;
  assign bus.tx_data_out  = data_q;
  assign bus.timeout_out  = tmo_pulse_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    tmo_d       = tmo_q;
    data_d      = data_q;
    pop         = 1'b0;
    tmo_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_head;
          hold_d  = HOLD_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          tmo_d   = TMO_LOAD;
          state_d = WAIT_HI;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      WAIT_HI: begin
        // Busy already high on entry is accepted as the rise.
        if (bus.busy_in) begin
          state_d = WAIT_LO;
        end else if (tmo_q == '0) begin
          tmo_pulse_d = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.busy_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      valid_q     <= (state_d == HOLD);
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

endmodule

// File: tb/tb_tx_byte_buffer.sv
// Scoreboard bench for tx_byte_buffer: stimulus queues expected bytes, a
// monitor checks each issued byte, its hold length and data stability.
module tb_tx_byte_buffer;
  import tx_byte_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned TMO   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tx_byte_buffer_if #(.DEPTH(DEPTH)) bus ();

  tx_byte_buffer #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD),
    .TIMEOUT     (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q [$];
  int busy_mode = 2;  // 0: auto UART model, 1: forced high, 2: forced low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [WIDTH-1:0] b, input bit accept);
    bus.wr_valid_in = 1'b1;
    bus.wr_data_in  = b;
    if (accept) exp_q.push_back(b);
    tick();
    bus.wr_valid_in = 1'b0;
  endtask

  // UART busy model: rises 3 cycles after a valid rise, stays high 20 cycles.
  initial begin
    int   phase;
    logic pv;
    phase = -1;
    pv    = 1'b0;
    bus.busy_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (busy_mode == 0) begin
        if (bus.tx_valid_out && !pv) phase = 0;
        else if (phase >= 0) phase++;
        if (phase >= 23) phase = -1;
        bus.busy_in = (phase >= 3);
      end else begin
        phase = -1;
        bus.busy_in = (busy_mode == 1);
      end
      pv = bus.tx_valid_out;
    end
  end

  // Monitor
  logic             in_v = 1'b0;
  int               hold_len = 0;
  logic [WIDTH-1:0] cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_v     = 1'b0;
      hold_len = 0;
    end else if (bus.tx_valid_out) begin
      if (!in_v) begin
        in_v     = 1'b1;
        hold_len = 1;
        cur      = bus.tx_data_out;
        chk("busy_low_at_issue", bus.busy_in, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got 0x%0h, want none at %0t", bus.tx_data_out, $time);
        end else begin
          chk("byte_order", bus.tx_data_out, exp_q.pop_front());
        end
      end else begin
        hold_len++;
        chk("data_stable", bus.tx_data_out, cur);
      end
    end else if (in_v) begin
      chk("hold_len", hold_len, HOLD);
      in_v = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   peak;
    int   first_to;
    int   to_pulses;
    logic v20, v21;

    rst_n           = 1'b0;
    bus.wr_valid_in = 1'b0;
    bus.wr_data_in  = '0;
    #12;
    chk("rst_valid",    bus.tx_valid_out, 0);
    chk("rst_data",     bus.tx_data_out,  0);
    chk("rst_full",     bus.full_out,     0);
    chk("rst_empty",    bus.empty_out,    1);
    chk("rst_count",    bus.count_out,    0);
    chk("rst_overflow", bus.overflow_out, 0);
    chk("rst_timeout",  bus.timeout_out,  0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single byte
    busy_mode = 0;
    push_byte(8'hA5, 1'b1);
    chk("single_count_after_push", bus.count_out, 1);
    chk("single_empty_after_push", bus.empty_out, 0);
    tick();
    chk("single_count_after_pop", bus.count_out, 0);
    chk("single_valid", bus.tx_valid_out, 1);
    chk("single_data", bus.tx_data_out, 8'hA5);
    repeat (30) tick();
    chk("single_empty_end", bus.empty_out, 1);
    chk("single_queue_drained", exp_q.size(), 0);

    // Burst of three
    peak = 0;
    push_byte(8'h11, 1'b1);
    if (int'(bus.count_out) > peak) peak = int'(bus.count_out);
    push_byte(8'h22, 1'b1);
    if (int'(bus.count_out) > peak) peak = int'(bus.count_out);
    push_byte(8'h33, 1'b1);
    if (int'(bus.count_out) > peak) peak = int'(bus.count_out);
    repeat (90) begin
      tick();
      if (int'(bus.count_out) > peak) peak = int'(bus.count_out);
    end
    chk("burst_peak", peak, 2);
    chk("burst_empty_end", bus.empty_out, 1);
    chk("burst_queue_drained", exp_q.size(), 0);

    // Overflow with busy held high after the first issue
    push_byte(8'h40, 1'b1);
    repeat (5) tick();
    busy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      push_byte(8'hB0 + 8'(i), i < 8);
      chk("ovf_pulse", bus.overflow_out, (i >= 8) ? 1 : 0);
    end
    chk("ovf_full", bus.full_out, 1);
    chk("ovf_count", bus.count_out, DEPTH);
    tick();
    chk("ovf_pulse_end", bus.overflow_out, 0);

    // Release busy; push at the same edge the sequencer pops from full
    busy_mode = 0;
    tick();
    push_byte(8'hEE, 1'b0);
    chk("simul_count", bus.count_out, DEPTH - 1);
    chk("simul_overflow", bus.overflow_out, 1);
    chk("simul_full", bus.full_out, 0);
    repeat (220) tick();
    chk("ovf_empty_end", bus.empty_out, 1);
    chk("ovf_queue_drained", exp_q.size(), 0);

    // Timeout with busy held low
    busy_mode = 2;
    tick();
    push_byte(8'hC1, 1'b1);
    push_byte(8'hC2, 1'b1);
    first_to  = 0;
    to_pulses = 0;
    v20 = 1'b1;
    v21 = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (bus.timeout_out) begin
        to_pulses++;
        if (first_to == 0) first_to = k;
      end
      if (k == 20) v20 = bus.tx_valid_out;
      if (k == 21) v21 = bus.tx_valid_out;
    end
    chk("timeout_first_cycle", first_to, 20);
    chk("timeout_pulses", to_pulses, 2);
    chk("timeout_valid_at_pulse", v20, 0);
    chk("timeout_next_issue", v21, 1);
    repeat (3) tick();
    chk("timeout_empty_end", bus.empty_out, 1);
    chk("timeout_queue_drained", exp_q.size(), 0);

    // Reset mid-HOLD with three bytes queued
    busy_mode = 0;
    push_byte(8'hD1, 1'b1);
    push_byte(8'hD2, 1'b1);
    push_byte(8'hD3, 1'b1);
    push_byte(8'hD4, 1'b1);
    chk("prereset_count", bus.count_out, 3);
    chk("prereset_valid", bus.tx_valid_out, 1);
    busy_mode = 2;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.tx_valid_out, 0);
    chk("midrst_count", bus.count_out, 0);
    chk("midrst_empty", bus.empty_out, 1);
    chk("midrst_data", bus.tx_data_out, 0);
    chk("midrst_full", bus.full_out, 0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk("postrst_quiet", {bus.tx_valid_out, bus.overflow_out, bus.timeout_out}, 0);
    end
    chk("postrst_count", bus.count_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
